// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/decoder3to8.sv
// Binary index to one-hot decoder; all outputs low when disabled.
module decoder3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) dec_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/arb_rr8_ctrl.sv
// 8-requester round-robin arbiter holding each grant until the owner drops req.
// Optional tenure limit with a timeout pulse is compiled in by defining ARB_TIMEOUT_EN.
module arb_rr8_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    if (HOLD_MAX >= (1 << CNT_W)) begin : g_hold_range
        $error("HOLD_MAX must fit the tenure counter");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // First set request bit at or after the priority pointer, wrapping at NREQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        rr_pick = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = p + IDX_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en && (req != '0)) begin
                    state_d = BUSY;
                    idx_d   = rr_pick(req, ptr_q);
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if ((HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1))) begin
                    // Forced release: owner still requesting drops to lowest priority.
                    state_d = IDLE;
                    ptr_d   = idx_q + 1'b1;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign timeout = tout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt_vld = (state_q == BUSY);
    assign gnt_idx = idx_q;

    decoder3to8 u_dec (
        .idx_i (idx_q),
        .en_i  (gnt_vld),
        .dec_o (gnt)
    );

endmodule

// File: tb/tb_arb_rr8_ctrl.sv
// Scoreboard bench for arb_rr8_ctrl: driver steps a behavioural model, monitor compares each cycle.
module tb_arb_rr8_ctrl;

`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 0;
`endif
    localparam int unsigned DUT_HOLD = (HM != 0) ? HM : 16;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic       timeout;

    arb_rr8_ctrl #(.HOLD_MAX(DUT_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    // Behavioural model: owner (-1 = none), rotating start point, cycles held.
    int m_owner = -1, m_ptr = 0, m_idx = 0, m_held = 0, m_target = 1;
    bit m_to = 1'b0;

    task automatic model(input bit r, input bit e, input logic [7:0] rq);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_idx = 0; m_held = 0;
        end else if (m_owner < 0) begin
            if (e) begin
                for (int k = 0; k < 8; k++) begin
                    int i;
                    i = (m_ptr + k) % 8;
                    if (rq[i]) begin
                        m_owner  = i;
                        m_idx    = i;
                        m_held   = 1;
                        m_target = $urandom_range(1, 6);
                        break;
                    end
                end
            end
        end else if (!rq[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (HM != 0 && m_held == HM) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [7:0] rq);
        exp_t x;
        rst = r; en = e; req = rq;
        model(r, e, rq);
        x.gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        x.vld = (m_owner >= 0);
        x.idx = 3'(m_idx);
        x.to  = m_to;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checks++;
                if (gnt !== x.gnt) begin
                    failures++;
                    $display("FAIL gnt t=%0t got=%h exp=%h", $time, gnt, x.gnt);
                end
                checks++;
                if (gnt_vld !== x.vld) begin
                    failures++;
                    $display("FAIL gnt_vld t=%0t got=%b exp=%b", $time, gnt_vld, x.vld);
                end
                checks++;
                if (gnt_idx !== x.idx) begin
                    failures++;
                    $display("FAIL gnt_idx t=%0t got=%0d exp=%0d", $time, gnt_idx, x.idx);
                end
                checks++;
                if (timeout !== x.to) begin
                    failures++;
                    $display("FAIL timeout t=%0t got=%b exp=%b", $time, timeout, x.to);
                end
            end
        end
    end

    initial begin
        logic [7:0] rq;
        bit r, e;
        // Reset, then 0x81: requester 0 first, requester 7 after a gap.
        step(1, 0, 8'h00);
        step(0, 1, 8'h81);
        step(0, 1, 8'h81);
        step(0, 1, 8'h80);
        step(0, 1, 8'h80);
        step(0, 1, 8'h80);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        // All requesting, each owner drops after two cycles.
        step(1, 0, 8'h00);
        for (int c = 0; c < 30; c++) begin
            rq = 8'hFF;
            if (m_owner >= 0 && m_held >= 2) rq[m_owner] = 1'b0;
            step(0, 1, rq);
        end
        // Owner 7 releases while 0 and 7 request: pointer wraps to 0.
        step(1, 0, 8'h00);
        step(0, 1, 8'h80);
        step(0, 1, 8'h81);
        step(0, 1, 8'h01);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        // Enable gating: blocks new grants only.
        step(0, 0, 8'h10);
        step(0, 0, 8'h10);
        step(0, 1, 8'h10);
        step(0, 0, 8'h10);
        step(0, 0, 8'h10);
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        // Reset mid-tenure, then priority restarts at requester 0.
        step(0, 1, 8'h04);
        step(0, 1, 8'h04);
        step(1, 1, 8'h04);
        step(0, 1, 8'h05);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        // Two requesters held continuously (tenure limit exercised when enabled).
        step(1, 0, 8'h00);
        for (int c = 0; c < 14; c++) step(0, 1, 8'h06);
        step(0, 1, 8'h00);
        // Randomized traffic; owner holds for a random tenure.
        for (int c = 0; c < 800; c++) begin
            r  = ($urandom_range(0, 79) == 0);
            e  = ($urandom_range(0, 4) != 0);
            rq = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
            if (m_owner >= 0) rq[m_owner] = (m_held < m_target);
            step(r, e, rq);
        end
        step(0, 0, 8'h00);
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_rr8_ctrl.md
ARB_RR8_CTRL -- requirements
Module: arb_rr8_ctrl

Interface
REQ-001 Parameter HOLD_MAX, default 16, maximum grant tenure in cycles, legal 0..255, 0 = unlimited; only used when ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  arbiter enable; low blocks new grants but never revokes a current one.
REQ-005 req  input  8  per-requester request, bit i = requester i; a requester holds req high for its whole tenure.
REQ-006 gnt  output  8  registered one-hot grant, all zero when no owner.
REQ-007 gnt_vld  output  1  high exactly when gnt is non-zero.
REQ-008 gnt_idx  output  3  binary index of the current owner; holds the last owner while gnt_vld is low.
REQ-009 timeout  output  1  one-cycle pulse on forced release; tied 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-010 FSM states: IDLE (no owner) and BUSY (owner = gnt_idx); internal priority pointer ptr, 3 bits.
REQ-011 IDLE: with en=1 and req!=0, the winner is the first set req bit searching ptr, ptr+1, ... modulo 8; the next edge loads gnt_idx=winner and enters BUSY.
REQ-012 Request-to-grant latency: gnt/gnt_vld rise on the first edge after req is sampled in IDLE; no grant in the same cycle.
REQ-013 IDLE with en=0 or req=0: stay IDLE with gnt=0.
REQ-014 BUSY: gnt=one-hot(gnt_idx), gnt_vld=1, held while req[gnt_idx]=1, regardless of en or other req bits.
REQ-015 Release: req[gnt_idx] sampled 0 in BUSY -> next edge enters IDLE, gnt=0, ptr=gnt_idx+1 mod 8 (7 wraps to 0).
REQ-016 Minimum gap between consecutive grants: one cycle with gnt=0, including back-to-back requesters.
REQ-017 Simultaneous release and other requests: the released requester has lowest priority in the next arbitration.
REQ-018 Requests from non-owners in BUSY are ignored and not latched; arbitration uses live req in IDLE only.
REQ-019 gnt has at most one bit set on every cycle.

Reset
REQ-020 rst=1 at an edge: state=IDLE, gnt=0, gnt_vld=0, gnt_idx=0, ptr=0, tenure counter=0, timeout=0.
REQ-021 rst overrides every other input, including while BUSY; the grant drops at that edge with no timeout pulse.
REQ-022 The first arbitration after reset gives priority to requester 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: an 8-bit tenure counter clears on BUSY entry and increments each BUSY cycle.
REQ-024 When the counter reaches HOLD_MAX-1 with req[gnt_idx] still 1 and HOLD_MAX!=0, the next edge forces IDLE, ptr=gnt_idx+1, and timeout=1 for one cycle.
REQ-025 A requester that was forced off and keeps req high competes again at lowest priority.
REQ-026 Macro undefined: no counter, grants are unlimited, HOLD_MAX is ignored, and timeout is constant 0.

Structure
REQ-027 Shared package arb_pkg holds the state enum (IDLE, BUSY), NREQ=8, IDX_W=3 and CNT_W=8.
REQ-028 One sub-module, decoder3to8, drives gnt from gnt_idx with its enable tied to gnt_vld.
REQ-029 The rotating priority search is a combinational function in arb_rr8_ctrl.

Verification
REQ-030 Reset then req=8'h81 held -> gnt=8'h01 after 1 cycle; after release, 1 idle cycle, then gnt=8'h80.
REQ-031 All req=8'hFF, each owner drops after 2 cycles -> grant order 0,1,...,7,0 with a 1-cycle gap each.
REQ-032 Owner 7 releases while req=8'h81 -> ptr wraps to 0 -> gnt=8'h01.
REQ-033 en=0 with req=8'h10 -> gnt stays 0; en=1 -> gnt=8'h10 next cycle; en=0 mid-tenure -> grant retained.
REQ-034 rst asserted mid-BUSY with gnt=8'h04 -> gnt=0 and gnt_vld=0 at that edge; next grant starts from requester 0.
REQ-035 ARB_TIMEOUT_EN with HOLD_MAX=4 and req=8'h06 held -> gnt=8'h02 for 4 cycles, timeout pulse, then gnt=8'h04 for 4 cycles.
